// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-side and refill-side signals of the direct-mapped
// instruction cache, grouped into one bundle.
//
// Handshake rules:
//   fetch  : a request is accepted in a cycle where cpu_req && cpu_ready.
//            cpu_addr must be valid whenever cpu_req is high. cpu_rvalid is a
//            one-cycle pulse and cpu_rdata holds until the next pulse.
//   refill : mem_req stays high for the whole line burst and mem_addr is
//            stable while it is high. Each cycle with mem_rvalid high carries
//            one word, sequentially from line offset 0. Gaps are allowed.
//
// Modports:
//   master : fetch stage + backing memory (drives cpu_req/cpu_addr and the
//            refill response)
//   slave  : the cache itself
interface icache_dm_if;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output cpu_req, cpu_addr, mem_rvalid, mem_rdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata, mem_req, mem_addr
    );

    modport slave (
        input  cpu_req, cpu_addr, mem_rvalid, mem_rdata,
        output cpu_ready, cpu_rvalid, cpu_rdata, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache with line refill,
// sweeping invalidate and hit/miss counters.
//
// Ports:
//   clk, reset  : clock; synchronous active-high reset
//   bus         : icache_dm_if.slave (fetch request/response, refill burst)
//   flush       : invalidate-all request, remembered until the sweep ends
//   hit_count   : accepted hits (wrapping)
//   miss_count  : accepted misses (wrapping)
//   state_dbg   : current FSM state (IDLE=0, REFILL=1, RESPOND=2, FLUSH=3)
module icache_dm #(
    parameter int ADD_WIDTH  = 17,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic        clk,
    input  logic        reset,
    icache_dm_if.slave  bus,
    input  logic        flush,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [1:0]  state_dbg
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADD_WIDTH - 2 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, RESPOND, FLUSH} state_t;

    state_t state, state_next;

    logic [31:0]      data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [SETS-1:0]  valid;

    logic [TAG_W-1:0] req_tag, lat_tag;
    logic [IDX_W-1:0] req_idx, lat_idx, sweep;
    logic [OFF_W-1:0] req_off, lat_off, beat;
    logic [31:0]      crit_word;
    logic             flush_pending;
    logic             accept, hit, last_beat, sweep_done;
    logic             unused_addr_bits;

    // Bits above ADD_WIDTH alias by design; bits [1:0] select a byte.
    assign {req_tag, req_idx, req_off} = bus.cpu_addr[ADD_WIDTH-1:2];
    assign unused_addr_bits = ^{bus.cpu_addr[31:ADD_WIDTH], bus.cpu_addr[1:0]};

    assign accept     = (state == IDLE) && !flush_pending && !reset && bus.cpu_req;
    assign hit        = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign last_beat  = (state == REFILL) && bus.mem_rvalid && (beat == OFF_W'(LINE_WORDS - 1));
    assign sweep_done = (state == FLUSH) && (sweep == IDX_W'(SETS - 1));
    assign state_dbg  = state;

    always_comb begin
        state_next    = state;
        bus.cpu_ready = 1'b0;
        bus.mem_req   = 1'b0;
        case (state)
            IDLE: begin
                bus.cpu_ready = !flush_pending && !reset;
                if (flush_pending)
                    state_next = FLUSH;
                else if (accept && !hit)
                    state_next = REFILL;
            end
            REFILL: begin
                bus.mem_req = 1'b1;
                if (last_beat)
                    state_next = RESPOND;
            end
            RESPOND:  state_next = flush_pending ? FLUSH : IDLE;
            FLUSH:    if (sweep_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            valid          <= '0;
            flush_pending  <= 1'b0;
            hit_count      <= '0;
            miss_count     <= '0;
            bus.cpu_rvalid <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.mem_addr   <= '0;
            beat           <= '0;
            sweep          <= '0;
            lat_tag        <= '0;
            lat_idx        <= '0;
            lat_off        <= '0;
            crit_word      <= '0;
        end else begin
            state          <= state_next;
            bus.cpu_rvalid <= 1'b0;

            // A flush arriving mid-sweep is already covered by that sweep.
            if (sweep_done)
                flush_pending <= 1'b0;
            else if (flush)
                flush_pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            bus.cpu_rvalid <= 1'b1;
                            bus.cpu_rdata  <= data_mem[{req_idx, req_off}];
                            hit_count      <= hit_count + 32'd1;
                        end else begin
                            miss_count   <= miss_count + 32'd1;
                            lat_tag      <= req_tag;
                            lat_idx      <= req_idx;
                            lat_off      <= req_off;
                            beat         <= '0;
                            bus.mem_addr <= 32'({req_tag, req_idx, {OFF_W{1'b0}}, 2'b00});
                        end
                    end
                end
                REFILL: begin
                    if (bus.mem_rvalid) begin
                        beat <= beat + 1'b1;
                        if (beat == lat_off)
                            crit_word <= bus.mem_rdata;
                        if (last_beat) begin
                            valid[lat_idx] <= 1'b1;
                            bus.cpu_rvalid <= 1'b1;
                            // The critical word may be this very beat.
                            bus.cpu_rdata  <= (beat == lat_off) ? bus.mem_rdata : crit_word;
                        end
                    end
                end
                FLUSH: begin
                    valid[sweep] <= 1'b0;
                    sweep        <= sweep + 1'b1;  // wraps back to 0 for the next sweep
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; the valid flops qualify their contents.
    always_ff @(posedge clk) begin
        if (!reset && state == REFILL && bus.mem_rvalid)
            data_mem[{lat_idx, beat}] <= bus.mem_rdata;
        if (!reset && last_beat)
            tag_mem[lat_idx] <= lat_tag;
    end
endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache that replaces the flat single-cycle instruction memory in front of the RISC-V fetch stage. Hits return a registered word one cycle after acceptance. Misses refill a full line from a backing memory port over a valid-handshake burst. The block also provides a sweeping invalidate (flush) for self-modifying or reloaded code, plus hit/miss performance counters.

## Interface
- ADD_WIDTH, 17, byte-address bits decoded; cpu_addr[31:ADD_WIDTH] ignored
- LINE_WORDS, 4, 32-bit words per line, power of 2, ≥2
- SETS, 64, number of lines, power of 2, ≥2
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_req  in  1  fetch request
- cpu_addr  in  32  fetch byte address; bits [1:0] ignored
- cpu_ready  out  1  request accepted this cycle when cpu_req && cpu_ready
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
- cpu_rdata  out  32  fetched word, held until next cpu_rvalid
- flush  in  1  invalidate-all request (level; sampled as pending)
- mem_req  out  1  line refill request, held for whole burst
- mem_addr  out  32  line-aligned byte address of refill
- mem_rvalid  in  1  one refill word this cycle
- mem_rdata  in  32  refill word, sequential from offset 0
- hit_count  out  32  accepted hits, wrapping
- miss_count  out  32  accepted misses, wrapping

## Operation
- Address split on cpu_addr[ADD_WIDTH-1:2]: offset = low log2(LINE_WORDS) bits; index = next log2(SETS) bits; tag = remaining bits up to ADD_WIDTH-1.
- Storage: data array SETS×LINE_WORDS×32; tag array; valid bits as flops.
- FSM states: IDLE, REFILL, RESPOND, FLUSH.
- IDLE: cpu_ready = !flush_pending && !reset. On accept, look up index.
  - Hit (valid && tag match): cpu_rdata <= word, cpu_rvalid=1 next cycle, hit_count++. Stays IDLE, so back-to-back hits are accepted every cycle.
  - Miss: miss_count++, latch tag/index/offset, go to REFILL.
  - flush_pending set: go to FLUSH. No request is accepted in that cycle.
- REFILL: mem_req=1, mem_addr = {tag,index,offset=0,2'b00} zero-extended.
  - Each mem_rvalid writes the word at the beat counter position and increments the counter. The word whose position equals the latched offset is captured as the critical word.
  - On the LINE_WORDS-th beat: write tag, set valid, deassert mem_req next cycle, go to RESPOND.
- RESPOND: cpu_rvalid=1 with the critical word. Go to FLUSH if flush_pending, else IDLE. cpu_ready=0.
- FLUSH: counter sweeps set 0..SETS-1, clearing one valid bit per cycle (SETS cycles). Clears flush_pending, then returns to IDLE. cpu_ready=0.
- flush_pending is set by flush in any state. It is cleared only at the end of a FLUSH sweep. flush asserted during FLUSH does not restart the sweep.
- mem_rvalid outside REFILL is ignored.

## Timing
- Reset values: cpu_rvalid=0, cpu_rdata=0, mem_req=0, mem_addr=0, hit_count=0, miss_count=0, all valid=0, state=IDLE, flush_pending=0. cpu_ready=0 during reset, 1 in the first cycle after.
- Hit latency: accept at cycle t, cpu_rvalid at t+1.
- Miss latency: accept at t, mem_req high from t+1. If the last beat arrives at cycle k, cpu_rvalid is at k+1. With zero-wait memory, rvalid is at t+LINE_WORDS+2.
- mem_addr is stable while mem_req=1. Beats may have arbitrary gaps.
- Reset mid-refill: refill is abandoned, line stays invalid, mem_req=0 the next cycle.
- Address beyond ADD_WIDTH aliases; this is intended.
- Counters wrap 0xFFFFFFFF→0.

## Test plan
- Cold miss at 0x00000010 (LINE_WORDS=4), memory returns 0xA0..0xA3 with zero wait → mem_addr=0x10, cpu_rdata=0xA0 at t+6, miss_count=1.
- Then back-to-back requests 0x14, 0x18, 0x1C on consecutive cycles → three consecutive cpu_rvalid with 0xA1, 0xA2, 0xA3; hit_count=3; mem_req stays 0.
- Conflict: fetch 0x10, then 0x10+4·LINE_WORDS·SETS (same index) → second access misses and refills. Re-fetching 0x10 misses again.
- Critical word with gapped beats: request 0x1C, one idle cycle between beats → cpu_rdata = 4th beat, one cycle after the last beat.
- flush pulsed during REFILL → refill completes and responds, then cpu_ready=0 for SETS cycles. The next fetch of the same address misses.
- Reset asserted mid-refill, then stray mem_rvalid beats → mem_req=0, counters 0, no cpu_rvalid. The first fetch after reset misses.
